q_serializer: RTL and testbench

- Synthesizable transmitter for the serialized-charge pulse protocol. It is the sending end of the link that the Q-measurement receiver in top decodes.
- Converts a charge value into a train of fixed-width pulses on q_serialized, one pulse per Q_PER_PULSE units. It then holds the line low long enough for the receiver watchdog to close the measurement.
- Replaces the behavioural resonant-system emulation on silicon-facing benches and in loopback configurations of top.

---
 rtl/q_link_pkg.sv | 27 ++
 rtl/phase_timer.sv | 41 ++++
 rtl/q_serializer.sv | 156 +++++++++++++++
 tb/tb_q_serializer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/q_link_pkg.sv
// Shared definitions for the serialized-charge pulse link.
// The transmitter (q_serializer) and the receiver both import these values,
// so the two ends of the link agree on the protocol constants.
//   - q_state_e : transmitter state encoding
//   - Def*      : default protocol constants
//   - max3      : elaboration helper used to size the phase timer
package q_link_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHigh,
        StGap,
        StSilence,
        StDone
    } q_state_e;

    localparam int unsigned DefQPerPulse    = 5;
    localparam int unsigned DefPulseDuration = 3;
    localparam int unsigned DefWtdBusWidth  = 3;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with a terminal-count flag.
// Times the HIGH, GAP and SILENCE phases of the transmitter.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active-low
//   load       : load load_value this cycle (has priority over counting)
//   load_value : value to load; a phase of D cycles is loaded with D-1
//   tc         : high while the counter is zero (last cycle of the phase)
module phase_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/q_serializer.sv
// Serialized-charge pulse transmitter.
// Emits floor(q_value/Q_PER_PULSE) pulses of PULSE_DURATION high cycles,
// separated by GAP_DURATION low cycles, then holds the line low for
// SILENCE_CYCLES so the receiver watchdog closes the measurement.
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous reset, active-low
//   start        : send request, accepted when start && ready
//   q_value      : charge to send, sampled on acceptance
//   ready        : idle (or in the final DONE cycle) and able to accept
//   q_serialized : registered pulse-train output
//   done         : one-cycle strobe at the end of a transaction
//   q_sent       : charge actually sent, valid with done, held afterwards
//   pulse_count  : pulses emitted in the current/last transaction
module q_serializer
    import q_link_pkg::*;
#(
    parameter int unsigned BUS_WIDTH      = 10,
    parameter int unsigned Q_PER_PULSE    = DefQPerPulse,
    parameter int unsigned PULSE_DURATION = DefPulseDuration,
    parameter int unsigned GAP_DURATION   = 2,
    parameter int unsigned WTD_BUS_WIDTH  = DefWtdBusWidth,
    parameter int unsigned SILENCE_CYCLES = 2 ** WTD_BUS_WIDTH + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BUS_WIDTH-1:0] q_value,
    output logic                 ready,
    output logic                 q_serialized,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] q_sent,
    output logic [BUS_WIDTH-1:0] pulse_count
);

    localparam int unsigned MaxPhase = max3(PULSE_DURATION, GAP_DURATION, SILENCE_CYCLES);
    localparam int unsigned TimerW   = $clog2(MaxPhase + 1);

    localparam logic [BUS_WIDTH-1:0] Qpp         = BUS_WIDTH'(Q_PER_PULSE);
    localparam logic [TimerW-1:0]    PulseLoad   = TimerW'(PULSE_DURATION - 1);
    localparam logic [TimerW-1:0]    GapLoad     = TimerW'(GAP_DURATION - 1);
    localparam logic [TimerW-1:0]    SilenceLoad = TimerW'(SILENCE_CYCLES - 1);

    // The receiver needs strictly more silence than its watchdog period.
    if (SILENCE_CYCLES <= 2 ** WTD_BUS_WIDTH) begin : g_bad_silence
        $error("SILENCE_CYCLES must exceed 2**WTD_BUS_WIDTH");
    end
    if (Q_PER_PULSE < 1 || PULSE_DURATION < 1 || GAP_DURATION < 1) begin : g_bad_timing
        $error("Q_PER_PULSE, PULSE_DURATION and GAP_DURATION must be >= 1");
    end

    q_state_e             state_q, state_d;
    logic [BUS_WIDTH-1:0] rem_q, rem_d;
    logic [BUS_WIDTH-1:0] pc_q, pc_d;
    logic [BUS_WIDTH-1:0] sent_q, sent_d;
    logic                 ser_q;

    logic                 tmr_load;
    logic [TimerW-1:0]    tmr_value;
    logic                 tmr_tc;

    phase_timer #(
        .WIDTH(TimerW)
    ) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_value(tmr_value),
        .tc        (tmr_tc)
    );

    // DONE doubles as an accept slot so transactions can run back to back.
    assign ready = (state_q == StIdle) || (state_q == StDone);
    assign done  = (state_q == StDone);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        pc_d      = pc_q;
        sent_d    = sent_q;
        tmr_load  = 1'b0;
        tmr_value = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    rem_d    = q_value;
                    pc_d     = '0;
                    tmr_load = 1'b1;
                    if (q_value >= Qpp) begin
                        state_d   = StHigh;
                        tmr_value = PulseLoad;
                    end else begin
                        state_d   = StSilence;
                        tmr_value = SilenceLoad;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StHigh: begin
                if (tmr_tc) begin
                    rem_d    = rem_q - Qpp;
                    pc_d     = pc_q + BUS_WIDTH'(1);
                    tmr_load = 1'b1;
                    if (rem_d >= Qpp) begin
                        state_d   = StGap;
                        tmr_value = GapLoad;
                    end else begin
                        state_d   = StSilence;
                        tmr_value = SilenceLoad;
                    end
                end
            end
            StGap: begin
                if (tmr_tc) begin
                    state_d   = StHigh;
                    tmr_load  = 1'b1;
                    tmr_value = PulseLoad;
                end
            end
            StSilence: begin
                if (tmr_tc) begin
                    state_d = StDone;
                    // Constant multiply; pulse_count is stable throughout SILENCE.
                    sent_d  = pc_q * Qpp;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            pc_q    <= '0;
            sent_q  <= '0;
            ser_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pc_q    <= pc_d;
            sent_q  <= sent_d;
            // Registered from the next state so the line is high exactly in HIGH cycles.
            ser_q   <= (state_d == StHigh);
        end
    end

    assign q_serialized = ser_q;
    assign q_sent       = sent_q;
    assign pulse_count  = pc_q;

endmodule

// File: tb/tb_q_serializer.sv
// Self-checking bench for q_serializer with default parameters.
// Reference model: closed-form pulse schedule derived from q_value.
module tb_q_serializer;

    localparam int Q = 5;
    localparam int P = 3;
    localparam int G = 2;
    localparam int S = 10;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] q_value;
    logic       ready;
    logic       q_serialized;
    logic       done;
    logic [9:0] q_sent;
    logic [9:0] pulse_count;

    int n_checks;
    int n_fail;
    int exp_q_sent;

    q_serializer #(
        .BUS_WIDTH     (10),
        .Q_PER_PULSE   (5),
        .PULSE_DURATION(3),
        .GAP_DURATION  (2),
        .WTD_BUS_WIDTH (3),
        .SILENCE_CYCLES(10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .q_value     (q_value),
        .ready       (ready),
        .q_serialized(q_serialized),
        .done        (done),
        .q_sent      (q_sent),
        .pulse_count (pulse_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Sends v. Inputs are driven just after each negedge; the negedge before
    // edge k samples "cycle k" (acceptance edge = edge 0). If hold_from > 0,
    // start is raised with hold_v from cycle hold_from on, so it is ignored
    // while busy and accepted at the DONE edge.
    task automatic run_txn(input int v, input int hold_from, input int hold_v);
        int n, exp_done, obs_done, bad, first_bad, k;
        bit exp_ser, exp_rdy;
        int exp_pc, exp_sent;
        n        = v / Q;
        exp_done = (n > 0) ? n * P + (n - 1) * G + S + 1 : S + 1;
        obs_done = -1;
        bad      = 0;
        first_bad = -1;
        start   = 1'b1;
        q_value = 10'(v);
        @(posedge clk);
        k = 0;
        while (obs_done < 0 && k < exp_done + 3) begin
            k++;
            @(negedge clk);
            exp_ser = 1'b0;
            if (n > 0 && k <= n * (P + G) - G) exp_ser = (((k - 1) % (P + G)) < P);
            if (k <= P) exp_pc = 0;
            else begin
                exp_pc = (k - 1 - P) / (P + G) + 1;
                if (exp_pc > n) exp_pc = n;
            end
            exp_rdy  = (k == exp_done);
            exp_sent = (k < exp_done) ? exp_q_sent : n * Q;
            if (q_serialized !== exp_ser || ready !== exp_rdy || done !== exp_rdy ||
                int'(pulse_count) != exp_pc || int'(q_sent) != exp_sent) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (done === 1'b1) obs_done = k;
            // Drive inputs for edge k.
            if (hold_from > 0 && k >= hold_from) begin
                start   = 1'b1;
                q_value = 10'(hold_v);
            end else begin
                start   = 1'b0;
                q_value = 10'($urandom_range(0, 1023));
            end
        end
        check_eq($sformatf("done_cycle q=%0d", v), obs_done, exp_done);
        check_eq($sformatf("trace_bad_cycles q=%0d first=%0d", v, first_bad), bad, 0);
        check_eq($sformatf("q_sent q=%0d", v), int'(q_sent), n * Q);
        check_eq($sformatf("pulse_count q=%0d", v), int'(pulse_count), n);
        exp_q_sent = n * Q;
    endtask

    initial begin
        int v, hf, hv;
        n_checks   = 0;
        n_fail     = 0;
        exp_q_sent = 0;
        rst     = 1'b0;
        start   = 1'b0;
        q_value = '0;
        #12;
        check_eq("rst_ready", int'(ready), 1);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_ser", int'(q_serialized), 0);
        check_eq("rst_q_sent", int'(q_sent), 0);
        check_eq("rst_pulse_count", int'(pulse_count), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_txn(23, 0, 0);
        run_txn(5, 0, 0);
        run_txn(0, 0, 0);
        run_txn(4, 0, 0);
        run_txn(1023, 0, 0);
        // Start held during a transaction, accepted at DONE.
        run_txn(23, 4, 50);
        run_txn(50, 0, 0);

        // Randomised, occasionally chained.
        hv = -1;
        for (int i = 0; i < 10; i++) begin
            if (hv >= 0) v = hv;
            else if (i % 3 == 0) v = $urandom_range(0, 14);
            else v = $urandom_range(0, 300);
            hv = -1;
            hf = 0;
            if ($urandom_range(0, 1) == 1) begin
                hv = $urandom_range(0, 60);
                hf = $urandom_range(1, 6);
            end
            run_txn(v, hf, hv);
        end
        if (hv >= 0) run_txn(hv, 0, 0);

        // Asynchronous reset during the second HIGH cycle of pulse 2 (cycle 7).
        @(negedge clk);
        start   = 1'b1;
        q_value = 10'd23;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("pre_rst_ser", int'(q_serialized), 1);
        check_eq("pre_rst_pulse_count", int'(pulse_count), 1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("async_rst_ser", int'(q_serialized), 0);
        check_eq("async_rst_ready", int'(ready), 1);
        check_eq("async_rst_pulse_count", int'(pulse_count), 0);
        check_eq("async_rst_q_sent", int'(q_sent), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q_sent = 0;
        @(negedge clk);
        run_txn(10, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
